// File: rtl/scroll_sequencer.sv
// scroll_sequencer: owns the 4-digit seven-segment display for the message path.
// Characters arrive over a valid/ready port into a small buffer. The block then
// scrolls a 4-character window across the message at a programmable tick rate
// and time-multiplexes that window onto the digit anodes. Code 4'hF is blank.
//
// Optional feature (compile-time macro SCROLL_BOUNCE_EN):
//   defined   -> ping-pong scrolling between offset 0 and max(len-4, 0)
//   undefined -> the window wraps from offset len-1 back to offset 0
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | accepting characters, display blank
// S_READY  | message complete, waiting for start, display blank
// S_SCROLL | stepping the window across the message every TICK_DIV cycles

module scroll_sequencer #(
    parameter int MSG_DEPTH = 16,
    parameter int TICK_DIV  = 50000000,
    parameter int SCAN_BITS = 18
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       wr_valid,
    input  logic [3:0] wr_code,
    input  logic       wr_last,
    output logic       wr_ready,
    input  logic       start,
    input  logic       stop,
    output logic       busy,
    output logic       loop_done,
    output logic [3:0] seg_code,
    output logic [3:0] an
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int TW = $clog2(TICK_DIV);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(MSG_DEPTH - 1);
    localparam logic [AW-1:0] OFF_ONE   = AW'(1);
    localparam logic [AW:0]   LEN_FOUR  = (AW + 1)'(4);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READY  = 2'd1,
        S_SCROLL = 2'd2
    } state_t;

    state_t               r_state;
    logic [3:0]           r_msg [MSG_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW:0]          r_len;
    logic [AW-1:0]        r_offset;
    logic [TW-1:0]        r_tick;
    logic [SCAN_BITS-1:0] r_scan;
    logic                 r_wr_ready;
    logic                 r_busy;
    logic                 r_loop_done;
`ifdef SCROLL_BOUNCE_EN
    logic                 r_dir_down;
    logic                 w_dir_nxt;
    logic [AW:0]          w_max;
`endif

    logic                 w_wr_fire;
    logic                 w_step;
    logic                 w_full;
    logic [AW:0]          w_off_ext;
    logic [AW:0]          w_len_m1;
    logic [AW-1:0]        w_off_nxt;
    logic                 w_wrap;
    logic [1:0]           w_sel;
    logic [AW:0]          w_idx;
    logic                 w_in_msg;

    // A write is only taken in IDLE; a concurrent stop discards it.
    assign w_wr_fire = (r_state == S_IDLE) && wr_valid && r_wr_ready && !stop;
    assign w_full    = (r_wr_ptr == PTR_LAST);
    assign w_step    = (r_state == S_SCROLL) && (r_tick == TICK_LAST);
    assign w_off_ext = {1'b0, r_offset};
    assign w_len_m1  = r_len - 1'b1;

`ifdef SCROLL_BOUNCE_EN
    // Upper turning point of the ping-pong; zero for messages that fit the window.
    assign w_max = (r_len > LEN_FOUR) ? (r_len - LEN_FOUR) : '0;
`endif

    // Offset and wrap flag that a scroll step would produce.
    always_comb begin
        w_off_nxt = r_offset;
        w_wrap    = 1'b0;
`ifdef SCROLL_BOUNCE_EN
        w_dir_nxt = r_dir_down;
        if (!r_dir_down) begin
            if (w_off_ext >= w_max) begin
                if (w_max == '0) begin
                    w_off_nxt = '0;
                    w_wrap    = 1'b1;
                end else begin
                    // Turn around; a turn from offset 1 lands straight on 0.
                    w_off_nxt = r_offset - 1'b1;
                    if (r_offset == OFF_ONE) begin
                        w_wrap = 1'b1;
                    end else begin
                        w_dir_nxt = 1'b1;
                    end
                end
            end else begin
                w_off_nxt = r_offset + 1'b1;
            end
        end else begin
            w_off_nxt = r_offset - 1'b1;
            if (r_offset == OFF_ONE) begin
                w_wrap    = 1'b1;
                w_dir_nxt = 1'b0;
            end
        end
`else
        if (w_off_ext == w_len_m1) begin
            w_off_nxt = '0;
            w_wrap    = 1'b1;
        end else begin
            w_off_nxt = r_offset + 1'b1;
        end
`endif
    end

    // Sequencing FSM with registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_len       <= '0;
            r_offset    <= '0;
            r_tick      <= '0;
            r_wr_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_loop_done <= 1'b0;
`ifdef SCROLL_BOUNCE_EN
            r_dir_down  <= 1'b0;
`endif
        end else begin
            r_loop_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (stop) begin
                        r_wr_ptr <= '0;
                        r_len    <= '0;
                    end else if (w_wr_fire) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        // A full buffer ends the message even without wr_last.
                        if (wr_last || w_full) begin
                            r_len      <= {1'b0, r_wr_ptr} + 1'b1;
                            r_state    <= S_READY;
                            r_wr_ready <= 1'b0;
                        end
                    end
                end
                S_READY: begin
                    if (stop) begin
                        r_state    <= S_IDLE;
                        r_wr_ptr   <= '0;
                        r_len      <= '0;
                        r_offset   <= '0;
                        r_wr_ready <= 1'b1;
                    end else if (start) begin
                        r_state    <= S_SCROLL;
                        r_offset   <= '0;
                        r_tick     <= '0;
                        r_busy     <= 1'b1;
`ifdef SCROLL_BOUNCE_EN
                        r_dir_down <= 1'b0;
`endif
                    end
                end
                S_SCROLL: begin
                    if (stop) begin
                        r_state    <= S_IDLE;
                        r_wr_ptr   <= '0;
                        r_len      <= '0;
                        r_offset   <= '0;
                        r_tick     <= '0;
                        r_busy     <= 1'b0;
                        r_wr_ready <= 1'b1;
                    end else if (w_step) begin
                        r_tick      <= '0;
                        r_offset    <= w_off_nxt;
                        r_loop_done <= w_wrap;
`ifdef SCROLL_BOUNCE_EN
                        r_dir_down  <= w_dir_nxt;
`endif
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wr_ptr   <= '0;
                    r_len      <= '0;
                    r_offset   <= '0;
                    r_tick     <= '0;
                    r_busy     <= 1'b0;
                    r_wr_ready <= 1'b1;
                end
            endcase
        end
    end

    // Message buffer; contents are only meaningful below r_len, so no reset.
    always_ff @(posedge clock) begin
        if (w_wr_fire) begin
            r_msg[r_wr_ptr] <= wr_code;
        end
    end

    // Free-running multiplex counter, runs in every state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scan <= '0;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    // Digit k shows msg[offset + 3 - k]; for a 2-bit select, 3 - k is ~k.
    assign w_sel    = r_scan[SCAN_BITS-1 -: 2];
    assign w_idx    = w_off_ext + {{(AW - 1){1'b0}}, ~w_sel};
    assign w_in_msg = (w_idx < r_len);

    // Selected digit code; the display is blank outside SCROLL or past the message end.
    always_comb begin
        seg_code = 4'hF;
        if ((r_state == S_SCROLL) && w_in_msg) begin
            seg_code = r_msg[w_idx[AW-1:0]];
        end
    end

    // Active-low one-hot anode drive for the selected digit.
    always_comb begin
        an = 4'b1110;
        case (w_sel)
            2'd0:    an = 4'b1110;
            2'd1:    an = 4'b1101;
            2'd2:    an = 4'b1011;
            2'd3:    an = 4'b0111;
            default: an = 4'b1110;
        endcase
    end

    assign wr_ready  = r_wr_ready;
    assign busy      = r_busy;
    assign loop_done = r_loop_done;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Testbench for scroll_sequencer with TICK_DIV=4, SCAN_BITS=4.
// Expected display codes, anodes and loop_done pulses are derived from the
// written message and the cycle count since start, queued, then compared.

module tb_scroll_sequencer;

    localparam int MSG_DEPTH = 16;
    localparam int TICK_DIV  = 4;
    localparam int SCAN_BITS = 4;
    localparam int SCAN_MOD  = 1 << SCAN_BITS;
    localparam int DIG_CYC   = 1 << (SCAN_BITS - 2);

    logic       clock;
    logic       reset_n;
    logic       wr_valid;
    logic [3:0] wr_code;
    logic       wr_last;
    logic       wr_ready;
    logic       start;
    logic       stop;
    logic       busy;
    logic       loop_done;
    logic [3:0] seg_code;
    logic [3:0] an;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] m_msg [MSG_DEPTH];
    int         m_len;
    int         tb_scan;

    typedef struct {
        logic [3:0] seg;
        logic [3:0] an;
        logic       ld;
        logic       busy;
    } exp_t;

    exp_t sb_q[$];

    scroll_sequencer #(
        .MSG_DEPTH(MSG_DEPTH),
        .TICK_DIV (TICK_DIV),
        .SCAN_BITS(SCAN_BITS)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_valid (wr_valid),
        .wr_code  (wr_code),
        .wr_last  (wr_last),
        .wr_ready (wr_ready),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .loop_done(loop_done),
        .seg_code (seg_code),
        .an       (an)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycles since reset release, modulo the scan period.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) tb_scan <= 0;
        else          tb_scan <= (tb_scan + 1) % SCAN_MOD;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Window offset after a given number of scroll steps.
    function automatic int model_offset(input int steps, input int len);
        int mx;
        int per;
        int pos;
`ifdef SCROLL_BOUNCE_EN
        mx = (len > 4) ? len - 4 : 0;
        if (mx == 0) return 0;
        per = 2 * mx;
        pos = steps % per;
        return (pos <= mx) ? pos : per - pos;
`else
        mx  = 0;
        per = 0;
        pos = 0;
        return steps % len;
`endif
    endfunction

    task automatic write_char(input logic [3:0] code, input logic last);
        wr_valid = 1'b1;
        wr_code  = code;
        wr_last  = last;
        @(posedge clock); #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(posedge clock); #1;
        stop = 1'b0;
        @(negedge clock);
        n_assert++;
        if (busy !== 1'b0 || wr_ready !== 1'b1 || seg_code !== 4'hF) begin
            n_fail++;
            $display("FAIL stop_to_idle: busy=%b wr_ready=%b seg=%h required busy=0 wr_ready=1 seg=f",
                     busy, wr_ready, seg_code);
        end
        @(posedge clock); #1;
    endtask

    // Pulse start, queue the expected display for ncyc cycles, then compare.
    task automatic start_and_check(input int ncyc, input string name);
        exp_t       e;
        int         s0;
        int         off;
        int         sel;
        int         idx;
        logic [3:0] an_e;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        s0 = tb_scan;
        for (int k = 0; k < ncyc; k++) begin
            off   = model_offset(k / TICK_DIV, m_len);
            sel   = ((s0 + k) % SCAN_MOD) / DIG_CYC;
            idx   = off + 3 - sel;
            an_e  = ~(4'b0001 << sel);
            e.seg = (idx < m_len) ? m_msg[idx] : 4'hF;
            e.an  = an_e;
            e.ld  = (k > 0) && (k % TICK_DIV == 0) && (off == 0);
            e.busy = 1'b1;
            sb_q.push_back(e);
        end
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clock);
            e = sb_q.pop_front();
            n_assert++;
            if (seg_code !== e.seg) begin
                n_fail++;
                $display("FAIL %s seg_code cyc=%0d: actual=%h required=%h", name, k, seg_code, e.seg);
            end
            n_assert++;
            if (an !== e.an) begin
                n_fail++;
                $display("FAIL %s an cyc=%0d: actual=%b required=%b", name, k, an, e.an);
            end
            n_assert++;
            if (loop_done !== e.ld) begin
                n_fail++;
                $display("FAIL %s loop_done cyc=%0d: actual=%b required=%b", name, k, loop_done, e.ld);
            end
            n_assert++;
            if (busy !== e.busy) begin
                n_fail++;
                $display("FAIL %s busy cyc=%0d: actual=%b required=%b", name, k, busy, e.busy);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_assert++;
        if (busy !== 1'b0 || wr_ready !== 1'b1 || loop_done !== 1'b0 ||
            seg_code !== 4'hF || an !== 4'b1110) begin
            n_fail++;
            $display("FAIL reset_values: busy=%b wr_ready=%b ld=%b seg=%h an=%b required 0 1 0 f 1110",
                     busy, wr_ready, loop_done, seg_code, an);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        n_assert++;
        if (busy !== 1'b0 || wr_ready !== 1'b1 || seg_code !== 4'hF || an !== 4'b1110) begin
            n_fail++;
            $display("FAIL after_release: busy=%b wr_ready=%b seg=%h an=%b required 0 1 f 1110",
                     busy, wr_ready, seg_code, an);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_hello();
        logic [3:0] codes [5];
        codes[0] = 4'h4; codes[1] = 4'h3; codes[2] = 4'h7; codes[3] = 4'h7; codes[4] = 4'h0;
        for (int i = 0; i < 5; i++) begin
            m_msg[i] = codes[i];
            write_char(codes[i], i == 4);
        end
        m_len = 5;
        @(negedge clock);
        n_assert++;
        if (wr_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hello_ready: wr_ready=%b busy=%b required 0 0", wr_ready, busy);
        end
        @(posedge clock); #1;
        start_and_check(TICK_DIV * 6 + 2, "hello");
        do_stop();
    endtask

    task automatic test_full_buffer();
        for (int i = 0; i < MSG_DEPTH; i++) begin
            m_msg[i] = 4'(i);
            if (i == MSG_DEPTH - 1) begin
                @(negedge clock);
                n_assert++;
                if (wr_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_before_last: wr_ready=%b required=1", wr_ready);
                end
                @(posedge clock); #1;
            end
            write_char(4'(i), 1'b0);
        end
        m_len = MSG_DEPTH;
        wr_valid = 1'b1;
        wr_code  = 4'h9;
        @(negedge clock);
        n_assert++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: wr_ready=%b required=0", wr_ready);
        end
        @(posedge clock); #1;
        wr_valid = 1'b0;
        @(negedge clock);
        n_assert++;
        if (wr_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_17th: wr_ready=%b busy=%b required 0 0", wr_ready, busy);
        end
        @(posedge clock); #1;
        start_and_check(TICK_DIV * 3, "full");
        do_stop();
    endtask

    task automatic test_start_stop_same();
        write_char(4'h1, 1'b0);
        write_char(4'h2, 1'b1);
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_assert++;
            if (busy !== 1'b0 || wr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL start_stop_same cyc=%0d: busy=%b wr_ready=%b required 0 1", i, busy, wr_ready);
            end
            @(posedge clock); #1;
        end
        m_msg[0] = 4'hA;
        m_len    = 1;
        write_char(4'hA, 1'b1);
        start_and_check(TICK_DIV * 3 + 1, "single_char");
        do_stop();
    endtask

    task automatic test_start_in_idle();
        write_char(4'h5, 1'b0);
        write_char(4'h6, 1'b0);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_assert++;
            if (busy !== 1'b0 || wr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL start_in_idle cyc=%0d: busy=%b wr_ready=%b required 0 1", i, busy, wr_ready);
            end
            @(posedge clock); #1;
        end
        start = 1'b0;
        write_char(4'h8, 1'b1);
        @(negedge clock);
        n_assert++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_then_last: wr_ready=%b required=0", wr_ready);
        end
        @(posedge clock); #1;
        m_msg[0] = 4'h5; m_msg[1] = 4'h6; m_msg[2] = 4'h8;
        m_len = 3;
        start_and_check(TICK_DIV * 4, "len3");
        do_stop();
    endtask

    task automatic test_stop_partial();
        write_char(4'h1, 1'b0);
        write_char(4'h2, 1'b0);
        stop     = 1'b1;
        wr_valid = 1'b1;
        wr_code  = 4'hE;
        wr_last  = 1'b1;
        @(posedge clock); #1;
        stop     = 1'b0;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        @(negedge clock);
        n_assert++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_discard: wr_ready=%b required=1", wr_ready);
        end
        @(posedge clock); #1;
        m_msg[0] = 4'hC;
        m_len    = 1;
        write_char(4'hC, 1'b1);
        start_and_check(TICK_DIV * 2 + 1, "after_partial_stop");
        do_stop();
    endtask

    task automatic test_len6();
        for (int i = 0; i < 6; i++) begin
            m_msg[i] = 4'(i + 1);
            write_char(4'(i + 1), i == 5);
        end
        m_len = 6;
        start_and_check(TICK_DIV * 10, "len6");
    endtask

    // Entered while still scrolling from the previous scenario.
    task automatic test_reset_mid_scroll();
        reset_n = 1'b0;
        #1;
        n_assert++;
        if (busy !== 1'b0 || wr_ready !== 1'b1 || seg_code !== 4'hF ||
            an !== 4'b1110 || loop_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_scroll: busy=%b wr_ready=%b seg=%h an=%b ld=%b required 0 1 f 1110 0",
                     busy, wr_ready, seg_code, an, loop_done);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        n_assert++;
        if (busy !== 1'b0 || wr_ready !== 1'b1 || seg_code !== 4'hF || an !== 4'b1110) begin
            n_fail++;
            $display("FAIL reset_mid_release: busy=%b wr_ready=%b seg=%h an=%b required 0 1 f 1110",
                     busy, wr_ready, seg_code, an);
        end
        @(posedge clock); #1;
        m_msg[0] = 4'h2; m_msg[1] = 4'hB;
        m_len = 2;
        write_char(4'h2, 1'b0);
        write_char(4'hB, 1'b1);
        start_and_check(TICK_DIV * 3, "after_reset");
        do_stop();
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_code  = 4'h0;
        wr_last  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        m_len    = 0;
        for (int i = 0; i < MSG_DEPTH; i++) m_msg[i] = 4'hF;
        @(posedge clock); #1;
        test_reset();
        test_hello();
        test_full_buffer();
        test_start_stop_same();
        test_start_in_idle();
        test_stop_partial();
        test_len6();
        test_reset_mid_scroll();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
